// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of maindecoder. It holds the PC and keeps at most one
//   instruction-memory read in flight. Each returned word is handed to decode
//   over a valid/ready handshake, together with the PC it was fetched from.
//   After a handoff the PC advances sequentially by 4 (wrapping modulo 2^64).
//   A redirect replaces the PC and kills the current fetch. If a read is still
//   outstanding when the redirect arrives, the fetch stage waits for that stale
//   response and discards it.
//
//   Optional feature (macro FETCH_PERF_CNT_EN):
//     perf_fetched  - count of instructions accepted by decode
//     perf_wait     - count of cycles spent waiting on memory (WAIT or DROP)
//
// Parameters
//   RESET_PC        first PC fetched after reset
//
// Ports
//   clk             in   1   clock, rising edge
//   reset           in   1   synchronous reset, active-low
//   ireq_valid      out  1   read request to instruction memory
//   ireq_addr       out  64  request address (current PC, word aligned)
//   ireq_ready      in   1   memory accepts the request this cycle
//   iresp_valid     in   1   read data valid (in order)
//   iresp_data      in   32  instruction word
//   redirect_valid  in   1   load redirect_pc, kill current fetch
//   redirect_pc     in   64  new PC (low two bits ignored)
//   out_valid       out  1   instruction available to decode
//   out_instr       out  32  instruction word
//   out_pc          out  64  PC of out_instr
//   out_ready       in   1   decode accepts the instruction this cycle
//   perf_fetched    out  64  (FETCH_PERF_CNT_EN only)
//   perf_wait       out  64  (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   input  logic        out_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0] perf_fetched,
   output logic [63:0] perf_wait
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [63:0] PC_ALIGN_MASK = ~64'd3;
   localparam logic [63:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

   state_t      state_q;
   logic [63:0] pc_q;
   logic [31:0] instr_q;
   logic [63:0] opc_q;

   logic [63:0] redir_pc_d;
   logic [63:0] pc_inc_d;

   function automatic logic [63:0] align_pc(input logic [63:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

   assign redir_pc_d = align_pc(redirect_pc);
   assign pc_inc_d   = pc_q + 64'd4;   // natural wrap at 2^64

   // A redirect in the same cycle suppresses the request so that the old PC
   // never reaches memory once it has been superseded.
   assign ireq_valid = (state_q == S_REQ) && !redirect_valid && reset;
   assign ireq_addr  = pc_q;

   assign out_valid  = (state_q == S_HOLD);
   assign out_instr  = instr_q;
   assign out_pc     = opc_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC_AL;
         instr_q <= '0;
         opc_q   <= '0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (redirect_valid) begin
                  pc_q <= redir_pc_d;
               end else if (ireq_ready) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc_q <= redir_pc_d;
                  // Response arriving with the redirect is simply dropped;
                  // otherwise it is still owed and must be absorbed in DROP.
                  state_q <= iresp_valid ? S_REQ : S_DROP;
               end else if (iresp_valid) begin
                  instr_q <= iresp_data;
                  opc_q   <= pc_q;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc_q    <= redir_pc_d;
                  state_q <= S_REQ;
               end else if (out_ready) begin
                  pc_q    <= pc_inc_d;
                  state_q <= S_REQ;
               end
            end
            S_DROP: begin
               if (redirect_valid) begin
                  pc_q <= redir_pc_d;
               end
               if (iresp_valid) begin
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [63:0] fetched_q;
   logic [63:0] wait_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetched_q <= '0;
         wait_q    <= '0;
      end else begin
         if (out_valid && out_ready && !redirect_valid) begin
            fetched_q <= fetched_q + 64'd1;
         end
         if ((state_q == S_WAIT) || (state_q == S_DROP)) begin
            wait_q <= wait_q + 64'd1;
         end
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_wait    = wait_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Cycle-by-cycle directed vectors for instr_fetch. Each record holds the
//   inputs for one cycle and the outputs expected during that cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        ireq_ready;
   logic        iresp_valid;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [63:0] perf_fetched;
   logic [63:0] perf_wait;
`endif

   instr_fetch #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .ireq_ready     (ireq_ready),
      .iresp_valid    (iresp_valid),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_wait      (perf_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        redir;
      logic [63:0] rpc;
      logic        ordy;
      logic        e_iv;
      logic [63:0] e_addr;
      logic        e_ov;
      logic [31:0] e_instr;
      logic [63:0] e_pc;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int row   = 0;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst_n, input logic rdy, input logic rv,
                               input logic [31:0] rdata, input logic redir,
                               input logic [63:0] rpc, input logic ordy,
                               input logic e_iv, input logic [63:0] e_addr,
                               input logic e_ov, input logic [31:0] e_instr,
                               input logic [63:0] e_pc);
      vec_t v;
      v.rst_n = rst_n; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
      v.redir = redir; v.rpc = rpc; v.ordy = ordy;
      v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
      end
   endtask

   // Drive on the falling edge, compare shortly after, then let the rising
   // edge commit the cycle.
   task automatic run(input vec_t v);
      @(negedge clk);
      reset          = v.rst_n;
      ireq_ready     = v.rdy;
      iresp_valid    = v.rv;
      iresp_data     = v.rdata;
      redirect_valid = v.redir;
      redirect_pc    = v.rpc;
      out_ready      = v.ordy;
      #1;
      chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, v.e_iv});
      chk("ireq_addr", ireq_addr, v.e_addr);
      chk("out_valid", {63'd0, out_valid}, {63'd0, v.e_ov});
      if (v.e_ov) begin
         chk("out_instr", {32'd0, out_instr}, {32'd0, v.e_instr});
         chk("out_pc", out_pc, v.e_pc);
      end
      row++;
   endtask

   localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] a;
      logic [31:0] d;

      reset = 1'b0; ireq_ready = 1'b0; iresp_valid = 1'b0; iresp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

      // ------------------------------------------------------------ reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      ireq_ready = 1'b1;
      #1;
      chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);

      // ------------------------------------------------------------ table
      //                 rst rdy rv data          rd rpc               ordy iv addr              ov instr         pc
      // sequential fetch, 1-cycle latency
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0000,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h0050_0093, 0, 64'h0,           1,  0, 64'h8000_0000,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  0, 64'h8000_0000,   1, 32'h0050_0093, 64'h8000_0000));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0004,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h00A0_0113, 0, 64'h0,           1,  0, 64'h8000_0004,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  0, 64'h8000_0004,   1, 32'h00A0_0113, 64'h8000_0004));
      // redirect in WAIT, stale response two cycles later
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0008,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         1, 64'h8000_0100,   1,  0, 64'h8000_0008,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  0, 64'h8000_0100,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'hDEAD_BEEF, 0, 64'h0,           1,  0, 64'h8000_0100,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0100,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h1111_1111, 0, 64'h0,           1,  0, 64'h8000_0100,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  0, 64'h8000_0100,   1, 32'h1111_1111, 64'h8000_0100));
      // redirect together with the response
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0104,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h2222_2222, 1, 64'h8000_0200,   1,  0, 64'h8000_0104,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0200,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           1,  1, 64'h8000_0200,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h3333_3333, 0, 64'h0,           0,  0, 64'h8000_0200,   0, 32'h0,        64'h0));
      // redirect during HOLD
      tbl.push_back(mk(1, 0, 0, 32'h0,         1, 64'h8000_0300,   0,  0, 64'h8000_0200,   1, 32'h3333_3333, 64'h8000_0200));
      tbl.push_back(mk(1, 0, 0, 32'h0,         0, 64'h0,           0,  1, 64'h8000_0300,   0, 32'h0,        64'h0));
      // unaligned redirect, then wrap from the top of the address space
      tbl.push_back(mk(1, 1, 0, 32'h0,         1, 64'h8000_0103,   0,  0, 64'h8000_0300,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,         1, TOP,             0,  0, 64'h8000_0100,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           0,  1, TOP,             0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 1, 32'h4444_4444, 0, 64'h0,           0,  0, TOP,             0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,         0, 64'h0,           1,  0, TOP,             1, 32'h4444_4444, TOP));
      // response in REQ is a protocol error and is ignored
      tbl.push_back(mk(1, 0, 1, 32'h5555_5555, 0, 64'h0,           0,  1, 64'h0,           0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 1, 0, 32'h0,         0, 64'h0,           0,  1, 64'h0,           0, 32'h0,        64'h0));
      // redirects while in DROP, last one coincident with the stale response
      tbl.push_back(mk(1, 0, 0, 32'h0,         1, 64'h8000_0400,   0,  0, 64'h0,           0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,         1, 64'h8000_0500,   0,  0, 64'h8000_0400,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 1, 32'h6666_6666, 1, 64'h8000_0600,   0,  0, 64'h8000_0500,   0, 32'h0,        64'h0));
      tbl.push_back(mk(1, 0, 0, 32'h0,         0, 64'h0,           0,  1, 64'h8000_0600,   0, 32'h0,        64'h0));

      foreach (tbl[i]) run(tbl[i]);

      // ------------------------------------------------ decode back-pressure
      run(mk(1, 1, 0, 32'h0, 0, 64'h0, 0, 1, 64'h8000_0600, 0, 32'h0, 64'h0));
      run(mk(1, 1, 1, 32'h7777_7777, 0, 64'h0, 0, 0, 64'h8000_0600, 0, 32'h0, 64'h0));
      for (int i = 0; i < 5; i++) begin
         run(mk(1, 1, (i == 2), 32'hBAD0_BAD0, 0, 64'h0, 0,
                0, 64'h8000_0600, 1, 32'h7777_7777, 64'h8000_0600));
      end
      run(mk(1, 0, 0, 32'h0, 0, 64'h0, 1, 0, 64'h8000_0600, 1, 32'h7777_7777, 64'h8000_0600));
      run(mk(1, 0, 0, 32'h0, 0, 64'h0, 0, 1, 64'h8000_0604, 0, 32'h0, 64'h0));

      // ------------------------------------------------ reset while in WAIT
      run(mk(1, 1, 0, 32'h0, 0, 64'h0, 0, 1, 64'h8000_0604, 0, 32'h0, 64'h0));
      run(mk(0, 1, 0, 32'h0, 0, 64'h0, 0, 0, 64'h8000_0604, 0, 32'h0, 64'h0));
      run(mk(1, 0, 0, 32'h0, 0, 64'h0, 0, 1, 64'h8000_0000, 0, 32'h0, 64'h0));
      chk("rst2_out_instr", {32'd0, out_instr}, 64'd0);
      chk("rst2_out_pc", out_pc, 64'd0);

      // ------------------------------------------------ 2-cycle memory latency
      for (int k = 0; k < 4; k++) begin
         a = 64'h8000_0000 + 64'(4 * k);
         d = 32'hC0DE_0000 + 32'(k);
         run(mk(1, 1, 0, 32'h0, 0, 64'h0, 0, 1, a, 0, 32'h0, 64'h0));
         run(mk(1, 0, 0, 32'h0, 0, 64'h0, 0, 0, a, 0, 32'h0, 64'h0));
         run(mk(1, 0, 1, d,     0, 64'h0, 0, 0, a, 0, 32'h0, 64'h0));
         run(mk(1, 0, 0, 32'h0, 0, 64'h0, 1, 0, a, 1, d, a));
      end
      run(mk(1, 0, 0, 32'h0, 0, 64'h0, 0, 1, 64'h8000_0010, 0, 32'h0, 64'h0));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, 64'd4);
      chk("perf_wait", perf_wait, 64'd8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
